// File: rtl/uart_tx_word.sv
// uart_tx_word: serialises 32-bit TX FIFO words onto a UART line as back-to-back
// N-bit characters, LSB first. The frame format is latched from the shared CSR
// when each word is loaded.
// Ports:
//   clk, rst        system clock, asynchronous active-high reset
//   tick            one-cycle bit-rate enable; each tick advances one bit time
//   csr             [3:0] data bits N (0 = 8), [4] two stop bits,
//                   [5] parity enable, [6] odd parity
//   fifo_empty      TX FIFO empty
//   fifo_data       FIFO head word, show-ahead
//   fifo_rd         one-clk pop strobe
//   tx              serial line, registered, idles high
//   busy            high whenever a word is being sent
//   word_done       one-clk pulse when the last stop bit of a word ends
module uart_tx_word #(
    parameter int unsigned WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic [31:0]       csr,
    input  logic              fifo_empty,
    input  logic [WORD_W-1:0] fifo_data,
    output logic              fifo_rd,
    output logic              tx,
    output logic              busy,
    output logic              word_done
);

    localparam int unsigned CNT_W = 6;
    localparam int unsigned CHR_W = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP1  = 3'd4,
        STOP2  = 3'd5
    } state_e;

    state_e             state_q, state_d;
    logic [WORD_W-1:0]  sh_q, sh_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [CHR_W-1:0]   char_cnt_q, char_cnt_d;
    logic [CHR_W-1:0]   n_q, n_d;
    logic               two_q, two_d;
    logic               pen_q, pen_d;
    logic               odd_q, odd_d;
    logic               par_q, par_d;
    logic               lead_q, lead_d;
    logic               tx_q, tx_d;
    logic               busy_q, busy_d;
    logic               fifo_rd_q, fifo_rd_d;
    logic               word_done_q, word_done_d;
    logic               emit_c;
    logic               end_char_c;

    // csr[31:7] carries fields for other blocks
    logic unused_csr;
    assign unused_csr = ^csr[31:7];

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            sh_q        <= '0;
            bit_cnt_q   <= '0;
            char_cnt_q  <= '0;
            n_q         <= '0;
            two_q       <= 1'b0;
            pen_q       <= 1'b0;
            odd_q       <= 1'b0;
            par_q       <= 1'b0;
            lead_q      <= 1'b0;
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
            fifo_rd_q   <= 1'b0;
            word_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sh_q        <= sh_d;
            bit_cnt_q   <= bit_cnt_d;
            char_cnt_q  <= char_cnt_d;
            n_q         <= n_d;
            two_q       <= two_d;
            pen_q       <= pen_d;
            odd_q       <= odd_d;
            par_q       <= par_d;
            lead_q      <= lead_d;
            tx_q        <= tx_d;
            busy_q      <= busy_d;
            fifo_rd_q   <= fifo_rd_d;
            word_done_q <= word_done_d;
        end
    end

    // Next-state logic; tx_d is the line level for the bit time that starts
    // at this tick, so tx is driven straight from a flop.
    always_comb begin
        state_d     = state_q;
        sh_d        = sh_q;
        bit_cnt_d   = bit_cnt_q;
        char_cnt_d  = char_cnt_q;
        n_d         = n_q;
        two_d       = two_q;
        pen_d       = pen_q;
        odd_d       = odd_q;
        par_d       = par_q;
        lead_d      = lead_q;
        tx_d        = tx_q;
        fifo_rd_d   = 1'b0;
        word_done_d = 1'b0;
        emit_c      = 1'b0;
        end_char_c  = 1'b0;

        if (tick) begin
            unique case (state_q)
                IDLE: begin
                    tx_d = 1'b1;
                    if (!fifo_empty) begin
                        fifo_rd_d  = 1'b1;
                        sh_d       = fifo_data;
                        n_d        = (csr[3:0] == 4'd0) ? 4'd8 : csr[3:0];
                        two_d      = csr[4];
                        pen_d      = csr[5];
                        odd_d      = csr[6];
                        bit_cnt_d  = '0;
                        char_cnt_d = '0;
                        par_d      = 1'b0;
                        lead_d     = 1'b1;
                        state_d    = START;
                        tx_d       = 1'b0;
                    end
                end
                START: begin
                    // First character of a word holds start for an extra tick
                    if (lead_q) begin
                        lead_d = 1'b0;
                    end else begin
                        state_d = DATA;
                        emit_c  = 1'b1;
                    end
                end
                DATA: begin
                    if (char_cnt_q == n_q) begin
                        if (pen_q) begin
                            state_d = PARITY;
                            tx_d    = par_q ^ odd_q;
                        end else begin
                            state_d = STOP1;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        emit_c = 1'b1;
                    end
                end
                PARITY: begin
                    state_d = STOP1;
                    tx_d    = 1'b1;
                end
                STOP1: begin
                    if (two_q) begin
                        state_d = STOP2;
                        tx_d    = 1'b1;
                    end else begin
                        end_char_c = 1'b1;
                    end
                end
                STOP2: begin
                    end_char_c = 1'b1;
                end
                default: begin
                    state_d = IDLE;
                    tx_d    = 1'b1;
                end
            endcase
        end

        // Send the next data bit; zero fill supplies the padding of a short
        // last character. Parity accumulates over the whole word.
        if (emit_c) begin
            tx_d       = sh_q[0];
            sh_d       = {1'b0, sh_q[WORD_W-1:1]};
            par_d      = par_q ^ sh_q[0];
            char_cnt_d = char_cnt_q + CHR_W'(1);
            bit_cnt_d  = bit_cnt_q + CNT_W'(1);
        end

        // Stop bits done: next character back-to-back, or the word is finished
        if (end_char_c) begin
            if (bit_cnt_q < CNT_W'(WORD_W)) begin
                state_d    = START;
                lead_d     = 1'b0;
                char_cnt_d = '0;
                tx_d       = 1'b0;
            end else begin
                state_d     = IDLE;
                tx_d        = 1'b1;
                word_done_d = 1'b1;
            end
        end

        busy_d = (state_d != IDLE);
    end

    assign fifo_rd   = fifo_rd_q;
    assign tx        = tx_q;
    assign busy      = busy_q;
    assign word_done = word_done_q;

endmodule

// File: doc/uart_tx_word.md
Name: uart_tx_word

Overview:
- Serialises 32-bit words from the TX FIFO onto the serial line.
- Uses the frame format defined by the shared 32-bit CSR.
- Each word is sent LSB-first as back-to-back characters of N data bits until all 32 bits are out.
- Pairs with the word-assembling UART receiver on the same CSR; sits between the TX FIFO and the pad.

Parameters:
- WORD_W, 32: bits per FIFO word. The receiver pair requires 32.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- tick  in  1  one-cycle bit-rate enable; one serial bit time per tick.
- csr  in  32  [3:0] data bits per char N (0 means 8); [4] two stop bits; [5] parity enable; [6] odd parity (0 = even).
- fifo_empty  in  1  TX FIFO empty.
- fifo_data  in  WORD_W  FIFO head word, show-ahead (valid while !fifo_empty).
- fifo_rd  out  1  one-clk pop strobe.
- tx  out  1  serial line, registered; idle = 1.
- busy  out  1  high in any state except IDLE.
- word_done  out  1  one-clk pulse on the tick that ends the final stop bit of a word.

Behaviour:
- Reset (async) values: state = IDLE, tx = 1, fifo_rd = 0, busy = 0, word_done = 0, all counters = 0.
- A reset mid-frame aborts immediately: tx returns to 1 and the partial word is lost.
- All state and output updates occur only on clk edges where tick = 1. fifo_rd and word_done are exceptions: single-clk pulses.
- IDLE:
  - tx = 1.
  - On a tick with !fifo_empty: pulse fifo_rd for that clk.
  - Latch fifo_data into shift register sh.
  - Latch N, two-stop, parity-enable and odd from csr. CSR changes mid-word have no effect until the next load.
  - Clear bit_cnt and par. Go to START with lead = 1.
- START:
  - tx = 0.
  - If lead = 1 (first character of a word): hold START for 2 ticks. This matches the receiver's idle-detect tick plus start-state tick.
  - Continuation characters: START lasts 1 tick.
  - Clear char_cnt; then go to DATA.
- DATA:
  - tx = sh[0] each tick, then sh >>= 1 with zero fill.
  - par ^= the transmitted bit; char_cnt++ and bit_cnt++.
  - After N ticks: go to PARITY if parity enabled, else STOP1.
- PARITY: tx = par when even, ~par when odd; 1 tick; then STOP1.
- STOP1: tx = 1, 1 tick. Then:
  - STOP2 if two-stop;
  - else START (lead = 0) if bit_cnt < 32;
  - else IDLE with word_done pulse.
- STOP2: tx = 1, 1 tick. Then START (lead = 0) if bit_cnt < 32, else IDLE with word_done pulse.
- Partial last character: when 32 is not a multiple of N, the last character still sends N bits. Bits beyond bit 31 are 0 and included in parity.
- Counter widths: bit_cnt is 6 bits and saturates meaningfully at up to 32+14. char_cnt is 4 bits.
- Characters within a word are back-to-back with no idle gap.
- Between words there is at least one IDLE tick with tx = 1. A pop occurs on the first IDLE tick where the FIFO is non-empty.
- fifo_rd is never asserted when fifo_empty = 1, and never outside IDLE.
- Tick-cycle count per word: 1 + ceil(32/N)·(1 + N + P + S), where P is 0 or 1 and S is 1 or 2.

Test Plan:
- N=8, no parity, 1 stop, word 0xA5C3_0F81:
  - 4 chars, 41 tick-cycles busy.
  - Char 0 on tx: 0,0,1,0,0,0,0,0,0,1,1, showing the double start.
  - Chars 1–3 each 10 bits; word_done pulses once; fifo_rd pulses once.
- Same word, parity on: even gives char 0 parity 0 (0x81 has 2 ones); odd gives 1.
  - Check the 0x0F char: even parity = 0.
- N=5, even parity, 2 stops, word 0xFFFF_FFFF:
  - 7 chars.
  - Last char data = 1,1,0,0,0 with parity 0.
  - Stop bits 1,1 each char.
- csr[3:0]=0 behaves identically to N=8.
- csr[3:0] rewritten to 4 mid-word: the current word stays 8-bit.
- FIFO holding 2 words:
  - Exactly 1 IDLE tick with tx=1 between words.
  - Second fifo_rd occurs on that tick.
  - fifo_rd is never asserted while empty.
- Assert rst during DATA of char 2:
  - tx=1, busy=0, state IDLE immediately.
  - After release, the next word starts from bit 0 with the double start bit.
